// File: rtl/nnrv_pkg.sv
// nnrv_pkg: shared constants and packed-bus helpers for the nnrv register file slice.
package nnrv_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned REG_NUM_DEF  = 32;
  localparam int unsigned AW_DEF       = $clog2(REG_NUM_DEF);
  localparam int unsigned RD_PORTS_DEF = 2;

  // Low bit of lane `port` in a packed bus made of `width`-bit lanes.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/nnrv_scoreboard.sv
// nnrv_scoreboard: one pending bit per register plus a running count of pending registers.
import nnrv_pkg::*;

module nnrv_scoreboard #(
  parameter int unsigned REG_NUM = REG_NUM_DEF,
  localparam int unsigned AW = $clog2(REG_NUM)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rsv_en,
  input  logic [AW-1:0]      i_rsv,
  input  logic               i_clr_en,
  input  logic [AW-1:0]      i_clr,
  output logic [REG_NUM-1:0] o_pend,
  output logic [AW:0]        o_busy_cnt
);

  logic [REG_NUM-1:0] pend_r;
  logic [REG_NUM-1:0] pend_nxt_s;
  logic [AW:0]        cnt_r;
  logic [AW:0]        cnt_nxt_s;
  logic               set_s;
  logic               clr_s;

  // Next pending state: a reserve of the same index masks the clear, so set and clear never collide.
  always_comb begin
    set_s      = i_rsv_en && (i_rsv != '0) && !pend_r[i_rsv];
    clr_s      = i_clr_en && (i_clr != '0) && pend_r[i_clr] && !(i_rsv_en && (i_rsv == i_clr));
    pend_nxt_s = pend_r;
    pend_nxt_s[i_clr] = clr_s ? 1'b0 : pend_nxt_s[i_clr];
    pend_nxt_s[i_rsv] = set_s ? 1'b1 : pend_nxt_s[i_rsv];
    cnt_nxt_s  = cnt_r + {{AW{1'b0}}, set_s} - {{AW{1'b0}}, clr_s};
  end

  // Pending bits and count registered together so the count always matches the bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_r <= '0;
      cnt_r  <= '0;
    end else begin
      pend_r <= pend_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign o_pend     = pend_r;
  assign o_busy_cnt = cnt_r;

endmodule

// File: rtl/nnrv_regfile_sb.sv
// nnrv_regfile_sb: multi-read-port register file (x0 hard-wired to zero) with a pending-write scoreboard.
// Define NNRV_REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
import nnrv_pkg::*;

module nnrv_regfile_sb #(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned REG_NUM  = REG_NUM_DEF,
  parameter int unsigned RD_PORTS = RD_PORTS_DEF,
  localparam int unsigned AW = $clog2(REG_NUM)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [RD_PORTS-1:0]      i_rd_en,
  input  logic [RD_PORTS*AW-1:0]   i_rd_idx,
  input  logic                     i_w_en,
  input  logic [AW-1:0]            i_w,
  input  logic [XLEN-1:0]          i_w_reg,
  input  logic                     i_rsv_en,
  input  logic [AW-1:0]            i_rsv,
  output logic [RD_PORTS*XLEN-1:0] o_rd_reg,
  output logic [RD_PORTS-1:0]      o_rd_busy,
  output logic [AW:0]              o_busy_cnt
);

  logic [XLEN-1:0]    regs_r [REG_NUM];
  logic [REG_NUM-1:0] pend_s;

  // Register array; index 0 is only ever written by reset, which keeps x0 at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        regs_r[r] <= '0;
      end
    end else if (i_w_en && (i_w != '0)) begin
      regs_r[i_w] <= i_w_reg;
    end
  end

  nnrv_scoreboard #(
    .REG_NUM (REG_NUM)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rsv_en   (i_rsv_en),
    .i_rsv      (i_rsv),
    .i_clr_en   (i_w_en),
    .i_clr      (i_w),
    .o_pend     (pend_s),
    .o_busy_cnt (o_busy_cnt)
  );

  for (genvar gp = 0; gp < RD_PORTS; gp++) begin : g_rd
    logic [AW-1:0] idx_s;

    assign idx_s = i_rd_idx[port_lsb(gp, AW) +: AW];

`ifdef NNRV_REGFILE_BYPASS_EN
    logic fwd_s;
    logic rsv_hit_s;

    // A same-index reserve keeps the port busy even while the write data is forwarded.
    assign fwd_s     = !i_rst && i_w_en && (i_w != '0) && (i_w == idx_s);
    assign rsv_hit_s = i_rsv_en && (i_rsv == idx_s);
    assign o_rd_reg[port_lsb(gp, XLEN) +: XLEN] = !i_rd_en[gp] ? '0 :
                                                  (fwd_s ? i_w_reg : regs_r[idx_s]);
    assign o_rd_busy[gp] = i_rd_en[gp] && pend_s[idx_s] && !(fwd_s && !rsv_hit_s);
`else
    assign o_rd_reg[port_lsb(gp, XLEN) +: XLEN] = i_rd_en[gp] ? regs_r[idx_s] : '0;
    assign o_rd_busy[gp] = i_rd_en[gp] && pend_s[idx_s];
`endif
  end

endmodule

// File: tb/tb_nnrv_regfile_sb.sv
// tb_nnrv_regfile_sb: directed and random checks of nnrv_regfile_sb against a reference model,
// expected values queued when stimulus is driven and compared when outputs are sampled.
import nnrv_pkg::*;

module tb_nnrv_regfile_sb;

  localparam int unsigned XL = XLEN_DEF;
  localparam int unsigned RN = REG_NUM_DEF;
  localparam int unsigned AW = AW_DEF;
  localparam int unsigned RP = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [RP-1:0]     rd_en;
  logic [RP*AW-1:0]  rd_idx;
  logic              w_en;
  logic [AW-1:0]     w_idx;
  logic [XL-1:0]     w_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_idx;
  logic [RP*XL-1:0]  rd_reg;
  logic [RP-1:0]     rd_busy;
  logic [AW:0]       busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [XL-1:0] m_regs [RN];
  logic [RN-1:0] m_pend;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  nnrv_regfile_sb #(
    .XLEN     (XL),
    .REG_NUM  (RN),
    .RD_PORTS (RP)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rd_en    (rd_en),
    .i_rd_idx   (rd_idx),
    .i_w_en     (w_en),
    .i_w        (w_idx),
    .i_w_reg    (w_data),
    .i_rsv_en   (rsv_en),
    .i_rsv      (rsv_idx),
    .o_rd_reg   (rd_reg),
    .o_rd_busy  (rd_busy),
    .o_busy_cnt (busy_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      e.tag = "empty_queue";
      e.val = 32'hFFFF_FFFF;
    end else begin
      e = exp_q.pop_front();
    end
    check_val(e.tag, obs, e.val);
  endtask

  function automatic logic [31:0] exp_rd(input logic en, input logic [AW-1:0] idx);
    if (!en) return 32'd0;
`ifdef NNRV_REGFILE_BYPASS_EN
    if (!rst && w_en && (w_idx != 5'd0) && (w_idx == idx)) return w_data;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic exp_busy(input logic en, input logic [AW-1:0] idx);
    if (!en || idx == 5'd0) return 1'b0;
`ifdef NNRV_REGFILE_BYPASS_EN
    if (!rst && w_en && (w_idx != 5'd0) && (w_idx == idx) && !(rsv_en && rsv_idx == idx)) return 1'b0;
`endif
    return m_pend[idx];
  endfunction

  // Drive both read ports, queue the model's answer, then compare once outputs settle.
  task automatic read_check(input string tag, input logic [1:0] en, input logic [AW-1:0] i0,
                            input logic [AW-1:0] i1);
    rd_en  = en;
    rd_idx = {i1, i0};
    push_exp({tag, "/d0"}, exp_rd(en[0], i0));
    push_exp({tag, "/d1"}, exp_rd(en[1], i1));
    push_exp({tag, "/b0"}, {31'd0, exp_busy(en[0], i0)});
    push_exp({tag, "/b1"}, {31'd0, exp_busy(en[1], i1)});
    push_exp({tag, "/cnt"}, 32'($countones(m_pend)));
    #1;
    pop_cmp(rd_reg[31:0]);
    pop_cmp(rd_reg[63:32]);
    pop_cmp({31'd0, rd_busy[0]});
    pop_cmp({31'd0, rd_busy[1]});
    pop_cmp({26'd0, busy_cnt});
  endtask

  // One clock edge: the model takes the same inputs the DUT samples, then strobes are dropped.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < RN; r++) m_regs[r] = 32'd0;
      m_pend = 32'd0;
    end else begin
      if (w_en && w_idx != 5'd0) m_regs[w_idx] = w_data;
      if (w_en && w_idx != 5'd0 && !(rsv_en && rsv_idx == w_idx)) m_pend[w_idx] = 1'b0;
      if (rsv_en && rsv_idx != 5'd0) m_pend[rsv_idx] = 1'b1;
    end
    #1;
    w_en   = 1'b0;
    rsv_en = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] idx, input logic [XL-1:0] d);
    w_en   = 1'b1;
    w_idx  = idx;
    w_data = d;
  endtask

  task automatic do_rsv(input logic [AW-1:0] idx);
    rsv_en  = 1'b1;
    rsv_idx = idx;
  endtask

  initial begin
    rst = 1'b1; rd_en = '0; rd_idx = '0; w_en = 1'b0; w_idx = '0; w_data = '0;
    rsv_en = 1'b0; rsv_idx = '0; m_pend = '0;
    for (int r = 0; r < RN; r++) m_regs[r] = 32'd0;
    tick();
    tick();
    read_check("reset", 2'b11, 5'd5, 5'd0);
    rst = 1'b0;

    do_write(5'd5, 32'hDEAD_BEEF);
    tick();
    read_check("wr_x5", 2'b11, 5'd5, 5'd0);

    do_write(5'd0, 32'h0000_1234);
    do_rsv(5'd0);
    tick();
    read_check("x0_ignored", 2'b11, 5'd0, 5'd0);

    do_rsv(5'd3);
    tick();
    do_rsv(5'd7);
    tick();
    read_check("rsv_3_7", 2'b11, 5'd3, 5'd7);
    do_write(5'd3, 32'h0000_0055);
    tick();
    read_check("clr_x3", 2'b11, 5'd3, 5'd7);

    do_rsv(5'd9);
    do_write(5'd9, 32'h0000_00A5);
    tick();
    read_check("rsv_wins", 2'b11, 5'd9, 5'd7);

    do_rsv(5'd10);
    do_write(5'd7, 32'h0000_0707);
    tick();
    read_check("set_clr_net0", 2'b11, 5'd10, 5'd7);

    do_rsv(5'd9);
    do_write(5'd11, 32'h0000_0B0B);
    tick();
    read_check("no_change", 2'b11, 5'd9, 5'd11);

    do_write(5'd4, 32'h0000_0011);
    tick();
    do_write(5'd4, 32'h0000_0077);
    read_check("bypass_x4", 2'b11, 5'd4, 5'd4);
    tick();
    do_write(5'd10, 32'h0000_0099);
    read_check("bypass_busy", 2'b11, 5'd4, 5'd10);
    tick();
    read_check("after_byp", 2'b11, 5'd4, 5'd10);
    read_check("rd_disabled", 2'b00, 5'd9, 5'd4);

    do_rsv(5'd1);
    tick();
    do_rsv(5'd2);
    tick();
    do_rsv(5'd3);
    tick();
    read_check("pre_rst", 2'b11, 5'd1, 5'd2);
    rst = 1'b1;
    do_write(5'd2, 32'h0000_2222);
    tick();
    read_check("rst_mid1", 2'b11, 5'd1, 5'd2);
    read_check("rst_mid2", 2'b11, 5'd3, 5'd5);
    rst = 1'b0;

    for (int i = 0; i < 80; i++) begin
      rst     = ($urandom_range(0, 24) == 0);
      w_en    = 1'($urandom_range(0, 1));
      w_idx   = 5'($urandom_range(0, 7));
      w_data  = $urandom;
      rsv_en  = 1'($urandom_range(0, 1));
      rsv_idx = 5'($urandom_range(0, 7));
      read_check("rnd", 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end
    rst = 1'b0;
    read_check("final", 2'b11, 5'd1, 5'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nnrv_regfile_sb.md
NNRV_REGFILE_SB -- requirements
Module: nnrv_regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter REG_NUM, default 32, register count; a power of two, at least 2.
REQ-003 SHALL have parameter RD_PORTS, default 2, number of independent read ports, range 1..4.
REQ-004 SHALL derive local AW = log2(REG_NUM), the register index width.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port i_rd_en, input, RD_PORTS bits: per-port read enable.
REQ-008 SHALL have port i_rd_idx, input, RD_PORTS*AW bits: per-port read index; port p occupies slice [p*AW +: AW].
REQ-009 SHALL have port i_w_en, input, 1 bit: write enable.
REQ-010 SHALL have port i_w, input, AW bits: write index.
REQ-011 SHALL have port i_w_reg, input, XLEN bits: write data.
REQ-012 SHALL have port i_rsv_en, input, 1 bit: reserve request, marks a register pending for an in-flight producer.
REQ-013 SHALL have port i_rsv, input, AW bits: reserve index.
REQ-014 SHALL have port o_rd_reg, output, RD_PORTS*XLEN bits: per-port read data.
REQ-015 SHALL have port o_rd_busy, output, RD_PORTS bits: per-port flag, set when the addressed register is pending.
REQ-016 SHALL have port o_busy_cnt, output, AW+1 bits: number of registers currently pending.

Function
REQ-017 SHALL hard-wire register 0 to zero; writes to index 0 and reserves of index 0 are ignored.
REQ-018 SHALL update regs[i_w] with i_w_reg on the rising edge when i_w_en=1 and i_w!=0.
REQ-019 SHALL drive read data combinationally: o_rd_reg[p] = regs[idx], or zero when i_rd_en[p]=0.
REQ-020 SHALL keep one pending bit per register in a scoreboard; reserve sets the bit and a write to the same index clears it, both at the rising edge.
REQ-021 SHALL let reserve win when reserve and write target the same nonzero index in the same cycle: the bit stays set and the data is still written.
REQ-022 SHALL leave the pending bit unchanged when a reserve targets an index that is already pending.
REQ-023 SHALL leave the pending bit unchanged when a write targets an index that is not pending.
REQ-024 SHALL drive o_rd_busy[p] combinationally from the pending bit of i_rd_idx[p]; it is 0 when i_rd_en[p]=0 or the index is 0.
REQ-025 SHALL keep o_busy_cnt equal to the population count of the pending bits, registered, with one cycle of latency after each edge.
REQ-026 SHALL let o_busy_cnt change by +1, -1 or 0 per cycle; a same-cycle set of one index and clear of another index nets to 0.
REQ-027 SHALL let all read ports access any index at once, including the same index, without conflict.

Reset
REQ-028 SHALL, at a rising edge with i_rst=1, clear every register to zero, clear every pending bit and set o_busy_cnt to 0.
REQ-029 SHALL give i_rst priority over any write or reserve in the same cycle; a reset mid-operation discards in-flight reservations.
REQ-030 SHALL keep o_rd_reg at zero and o_rd_busy at 0 while reset is held, since all state is zero.

Configuration
REQ-031 SHALL, with NNRV_REGFILE_BYPASS_EN defined, forward i_w_reg to every read port whose enabled index equals a same-cycle valid write index (nonzero), and force the matching o_rd_busy to 0 unless a same-index reserve also occurs.
REQ-032 SHALL, without NNRV_REGFILE_BYPASS_EN, return the pre-edge register contents and pending state, with no forwarding.

Structure
REQ-033 SHALL take the constants XLEN, REG_NUM and AW defaults and the slice helper for packed per-port buses from the shared package nnrv_pkg.
REQ-034 SHALL place the pending bits and o_busy_cnt in one sub-module, nnrv_scoreboard, parametrised by REG_NUM.

Verification
REQ-035 SHALL cover: reset, then write x5=0xDEADBEEF, then read port0 idx5 -> 0xDEADBEEF on the next cycle; port1 idx0 -> 0.
REQ-036 SHALL cover: write x0=0x1234 and reserve x0 -> read x0 returns 0, o_busy_cnt stays 0.
REQ-037 SHALL cover: reserve x3, then x7 -> o_busy_cnt=2 and o_rd_busy=1 on idx3; write x3=0x55 -> o_busy_cnt=1 and x3 busy clears.
REQ-038 SHALL cover: same-cycle reserve x9 and write x9=0xA5 -> x9 holds 0xA5 and stays busy, o_busy_cnt increments by 1.
REQ-039 SHALL cover: with bypass enabled, write x4=0x77 while port0 reads idx4 -> 0x77 in the same cycle; with bypass disabled -> the old value.
REQ-040 SHALL cover: reserve x1, x2, x3, then assert i_rst together with a write to x2 -> all registers 0, o_busy_cnt=0, no busy flags.
